// File: rtl/adsr_voice_scheduler_pkg.sv
// Shared encodings for the ADSR voice scheduler: envelope state codes, field widths,
// and the scheduler FSM states.
package adsr_voice_scheduler_pkg;
  localparam int STATE_W = 3;
  localparam int VOL_W   = 18;

  typedef enum logic [STATE_W-1:0] {
    ADSR_BLANK   = 3'd0,
    ADSR_ATTACK  = 3'd1,
    ADSR_DECAY   = 3'd2,
    ADSR_SUSTAIN = 3'd3,
    ADSR_RELEASE = 3'd4
  } adsr_state_e;

  typedef enum logic {
    SCH_IDLE  = 1'b0,
    SCH_SWEEP = 1'b1
  } sched_state_e;
endpackage

// File: rtl/adsr_voice_scheduler_flags.sv
// Per-voice pending note-on/note-off flags (module adsr_voice_flags).
// With ADSR_ALL_OFF_EN defined, a broadcast release input overrides everything else.
module adsr_voice_flags (
  input  logic clk,
  input  logic rst,
  input  logic set_on,
  input  logic set_off,
  input  logic step_clr,
`ifdef ADSR_ALL_OFF_EN
  input  logic all_off,
`endif
  output logic pressed,
  output logic released
);
  logic pressed_q, pressed_d;
  logic released_q, released_d;

  // Later assignments win: step clear < event < broadcast release.
  always_comb begin
    pressed_d  = pressed_q;
    released_d = released_q;
    if (step_clr) begin
      pressed_d  = 1'b0;
      released_d = 1'b0;
    end
    if (set_on) begin
      pressed_d  = 1'b1;
      released_d = 1'b0;
    end
    if (set_off) begin
      pressed_d  = 1'b0;
      released_d = 1'b1;
    end
`ifdef ADSR_ALL_OFF_EN
    if (all_off) begin
      pressed_d  = 1'b0;
      released_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign pressed  = pressed_q;
  assign released = released_q;
endmodule

// File: rtl/adsr_voice_scheduler.sv
// Time-multiplexed ADSR voice scheduler: every TICK_DIV clocks it sweeps all voices through an
// external step function and streams the new volumes. Optional macro: ADSR_ALL_OFF_EN (all_off port).
module adsr_voice_scheduler
  import adsr_voice_scheduler_pkg::*;
#(
  parameter int NVOICE   = 8,
  parameter int TICK_DIV = 64,
  localparam int VW      = $clog2(NVOICE),
  localparam int CW      = $clog2(TICK_DIV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic               evt_on,
  input  logic [VW-1:0]      evt_voice,
  output logic [STATE_W-1:0] step_state,
  output logic [VOL_W-1:0]   step_volume,
  output logic               step_pressed,
  output logic               step_released,
  input  logic [STATE_W-1:0] step_next_state,
  input  logic [VOL_W-1:0]   step_next_volume,
  output logic               vol_valid,
  output logic [VW-1:0]      vol_voice,
  output logic [VOL_W-1:0]   vol_data,
`ifdef ADSR_ALL_OFF_EN
  input  logic               all_off,
`endif
  output logic               sweep_done
);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [VW-1:0] VOICE_LAST = VW'(NVOICE - 1);

  sched_state_e        fsm_q, fsm_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [VW-1:0]       idx_q, idx_d;
  logic [STATE_W-1:0]  state_q [NVOICE];
  logic [STATE_W-1:0]  state_d [NVOICE];
  logic [VOL_W-1:0]    vol_q [NVOICE];
  logic [VOL_W-1:0]    vol_d [NVOICE];
  logic                vol_valid_q, vol_valid_d;
  logic [VW-1:0]       vol_voice_q, vol_voice_d;
  logic [VOL_W-1:0]    vol_data_q, vol_data_d;
  logic                done_q, done_d;
  logic                rdy_q, rdy_d;
  logic [NVOICE-1:0]   step_clr, pressed, released;
  logic                evt_fire;

  assign evt_fire = evt_valid & rdy_q;

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    cnt_d       = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
    state_d     = state_q;
    vol_d       = vol_q;
    vol_valid_d = 1'b0;
    vol_voice_d = vol_voice_q;
    vol_data_d  = vol_data_q;
    done_d      = 1'b0;
    rdy_d       = 1'b1;
    step_clr    = '0;
    case (fsm_q)
      SCH_IDLE: begin
        if (cnt_q == TICK_LAST) begin
          fsm_d = SCH_SWEEP;
          idx_d = '0;
        end
      end
      SCH_SWEEP: begin
        state_d[idx_q]  = step_next_state;
        vol_d[idx_q]    = step_next_volume;
        step_clr[idx_q] = 1'b1;
        vol_valid_d     = 1'b1;
        vol_voice_d     = idx_q;
        vol_data_d      = step_next_volume;
        if (idx_q == VOICE_LAST) begin
          fsm_d  = SCH_IDLE;
          idx_d  = '0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: fsm_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= SCH_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      vol_valid_q <= 1'b0;
      vol_voice_q <= '0;
      vol_data_q  <= '0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b0;
      for (int i = 0; i < NVOICE; i++) begin
        state_q[i] <= STATE_W'(ADSR_BLANK);
        vol_q[i]   <= '0;
      end
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      vol_valid_q <= vol_valid_d;
      vol_voice_q <= vol_voice_d;
      vol_data_q  <= vol_data_d;
      done_q      <= done_d;
      rdy_q       <= rdy_d;
      state_q     <= state_d;
      vol_q       <= vol_d;
    end
  end

  for (genvar g = 0; g < NVOICE; g++) begin : g_flags
    logic hit;
    assign hit = evt_fire && (evt_voice == VW'(g));
    adsr_voice_flags u_flags (
      .clk      (clk),
      .rst      (rst),
      .set_on   (hit & evt_on),
      .set_off  (hit & ~evt_on),
      .step_clr (step_clr[g]),
`ifdef ADSR_ALL_OFF_EN
      .all_off  (all_off),
`endif
      .pressed  (pressed[g]),
      .released (released[g])
    );
  end

  // idx_q rests at 0 in IDLE, so the step view shows voice 0 with its flags masked.
  assign step_state    = state_q[idx_q];
  assign step_volume   = vol_q[idx_q];
  assign step_pressed  = (fsm_q == SCH_SWEEP) & pressed[idx_q];
  assign step_released = (fsm_q == SCH_SWEEP) & released[idx_q];
  assign vol_valid     = vol_valid_q;
  assign vol_voice     = vol_voice_q;
  assign vol_data      = vol_data_q;
  assign sweep_done    = done_q;
  assign evt_ready     = rdy_q;
endmodule
